log_mult_sequencer: RTL and testbench
=====================================

Name: log_mult_sequencer

Overview:
- Sequential Mitchell-style logarithmic multiplier controller for the minimally biased multiplier datapath.
- Time-shares a single log-conversion unit between operands A and B, then sums the logarithms and applies the antilog shift.
- Accepts one operand pair per transaction over a valid/ready handshake and returns an approximate 2N-bit product over a second valid/ready handshake.
- Sits between the operand source and the product consumer; one transaction is in flight at a time.

Parameters:
N, 8, operand width; fraction width is N-1; product width is 2N.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_a  input  N  operand A, unsigned
in_b  input  N  operand B, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts the product
out_prod  output  2N  approximate product, unsigned
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_prod=0; busy=0; all internal registers cleared. Reset mid-transaction discards the transaction with no output.
- States: IDLE, LOG_A, LOG_B, SUM, ANTI, HOLD.
- IDLE: in_ready=1. When in_valid&&in_ready at edge T, register in_a and in_b, register zero_flag=(in_a==0)||(in_b==0), and go to LOG_A.
- LOG_A (T+1): shared log unit is muxed to A. Register kA = index of the leading one (0..N-1) and fA = the bits below the leading one, left-aligned to N-1 bits and zero-filled. Go to LOG_B.
- LOG_B (T+2): log unit is muxed to B. Register kB and fB. Go to SUM.
- SUM (T+3): K = kA+kB (width clog2(2N-1)); F = fA+fB (N bits).
  - If F[N-1]=1: E=K+1, M=F[N-2:0].
  - Else: E=K, M=F[N-2:0].
  - Register E and M. Go to ANTI.
- ANTI (T+4): out_prod = ({1'b1,M} << E) >> (N-1), truncated toward zero. Force out_prod to 0 if zero_flag. Assert out_valid. Go to HOLD.
- HOLD: out_valid=1; out_prod stable.
  - On out_ready, go to IDLE: out_valid=0 and in_ready=1 on the next cycle.
  - out_ready low means hold indefinitely.
- Latency: accept edge to out_valid high is 4 cycles. Minimum issue interval is 6 cycles, with no overlap.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored; operands are not sampled.
- out_ready outside HOLD is ignored.
- Zero operand: the log unit output for 0 is don't-care. Stages still run, and the product is forced to 0 at the same latency.
- Width rule: the maximum case E=2N-1 with M all-ones minus one still fits 2N bits. No overflow is possible; no saturation is needed.
- The log unit input mux select derives only from state, with no combinational path from in_* to out_*.

Decomposition:
- Shared package: state encoding enum (IDLE, LOG_A, LOG_B, SUM, ANTI, HOLD); localparams FRAC_W=N-1, PROD_W=2N, K_W=clog2(N), E_W=clog2(2N).
- Sub-module log_unit:
  - Combinational N-bit input; outputs k (K_W bits) and f (FRAC_W bits).
  - Built from a leading-one detector plus a normalising left shift by (N-1-k), with the leading one dropped.
  - A single instance is shared across LOG_A and LOG_B.
- FSM, operand and log registers, and the antilog shifter stay in log_mult_sequencer.

Test Plan:
- Reset/idle: assert rst_n=0 mid-SUM, then release -> out_valid=0, in_ready=1, busy=0, out_prod=0; the next transaction completes normally.
- Exact powers: in_a=8, in_b=8 -> kA=kB=3, F=0, out_prod=64 at exactly 4 cycles after accept.
- Fraction carry: in_a=3, in_b=3 -> F=128 carry, E=3, M=0, out_prod=8. Separately, in_a=5, in_b=6 -> F=96 no carry, E=4, out_prod=28.
- Max operands: in_a=255, in_b=255 -> E=15, M=126, out_prod=65024, with no wrap.
- Zero: in_a=0, in_b=200 -> out_prod=0 at 4-cycle latency. Also in_a=1, in_b=1 -> out_prod=1.
- Backpressure/handshake: hold out_ready=0 for 10 cycles -> out_prod stable, in_ready=0, a second in_valid is ignored. Then pulse out_ready -> IDLE the next cycle; back-to-back pairs (5,6),(255,255) yield 28 and 65024 in order.

Source files
------------

// File: rtl/log_mult_sequencer_pkg.sv
// rtl/log_mult_sequencer_pkg.sv - shared state encoding and default widths for the log multiplier
package log_mult_sequencer_pkg;

    localparam int N_DEF  = 8;
    localparam int FRAC_W = N_DEF - 1;
    localparam int PROD_W = 2 * N_DEF;
    localparam int K_W    = $clog2(N_DEF);
    localparam int E_W    = $clog2(2 * N_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOG_A,
        LOG_B,
        SUM,
        ANTI,
        HOLD
    } state_t;

endpackage

// File: rtl/log_mult_sequencer_log_unit.sv
// rtl/log_mult_sequencer_log_unit.sv - combinational leading-one detector and normaliser
module log_mult_sequencer_log_unit
    import log_mult_sequencer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         in_val,
    output logic [$clog2(N)-1:0] k,
    output logic [N-2:0]         f
);

    localparam int KW = $clog2(N);
    localparam int FW = N - 1;

    // Highest set bit wins; shifting it up to the MSB leaves the fraction in the bits below it.
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (in_val[i]) begin
                k = KW'(i);
            end
        end
        f = FW'(in_val << (KW'(N - 1) - k));
    end

endmodule

// File: rtl/log_mult_sequencer.sv
// rtl/log_mult_sequencer.sv - sequential Mitchell logarithmic multiplier with one shared log unit
module log_mult_sequencer
    import log_mult_sequencer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_prod,
    output logic           busy
);

    localparam int FW = N - 1;
    localparam int PW = 2 * N;
    localparam int KW = $clog2(N);
    localparam int EW = $clog2(2 * N);

    typedef logic [N+PW-2:0] wide_t;

    state_t          state;
    state_t          next_state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic            zero_flag;
    logic [KW-1:0]   ka;
    logic [KW-1:0]   kb;
    logic [FW-1:0]   fa;
    logic [FW-1:0]   fb;
    logic [EW-1:0]   e_reg;
    logic [FW-1:0]   m_reg;
    logic [PW-1:0]   prod_reg;
    logic [N-1:0]    log_in;
    logic [KW-1:0]   log_k;
    logic [FW-1:0]   log_f;
    logic [EW-1:0]   k_sum;
    logic [N-1:0]    f_sum;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);
    assign out_prod  = prod_reg;

    // The log unit input is selected purely by state, so no in_* to out_* path exists.
    assign log_in = (state == LOG_B) ? b_reg : a_reg;

    log_mult_sequencer_log_unit #(.N(N)) u_log (
        .in_val (log_in),
        .k      (log_k),
        .f      (log_f)
    );

    assign k_sum = EW'(ka) + EW'(kb);
    assign f_sum = {1'b0, fa} + {1'b0, fb};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing: fixed walk through the stages, waiting only on the two handshakes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = LOG_A;
            LOG_A:   next_state = LOG_B;
            LOG_B:   next_state = SUM;
            SUM:     next_state = ANTI;
            ANTI:    next_state = HOLD;
            HOLD:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers: operand capture, per-operand log, log sum, and antilog shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            zero_flag <= 1'b0;
            ka        <= '0;
            kb        <= '0;
            fa        <= '0;
            fb        <= '0;
            e_reg     <= '0;
            m_reg     <= '0;
            prod_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        zero_flag <= (in_a == '0) || (in_b == '0);
                    end
                end
                LOG_A: begin
                    ka <= log_k;
                    fa <= log_f;
                end
                LOG_B: begin
                    kb <= log_k;
                    fb <= log_f;
                end
                SUM: begin
                    // A fraction carry bumps the exponent; the mantissa keeps the low bits either way.
                    e_reg <= f_sum[N-1] ? k_sum + EW'(1) : k_sum;
                    m_reg <= f_sum[N-2:0];
                end
                ANTI: begin
                    prod_reg <= zero_flag ? '0
                                          : PW'((wide_t'({1'b1, m_reg}) << e_reg) >> (N - 1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_mult_sequencer.sv
// tb/tb_log_mult_sequencer.sv - scoreboard bench for the log multiplier sequencer
module tb_log_mult_sequencer;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_prod;
    logic           busy;

    typedef struct {
        int prod;
        int acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic        rdy_auto;
    logic        rdy_val;
    logic        prev_v;
    logic [15:0] prev_p;

    log_mult_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: floor log2 and the exact fractional remainder, summed and raised back.
    function automatic int model(input int a, input int b);
        int ka, kb, fa, fb, ff, kk;
        if (a == 0 || b == 0) return 0;
        ka = $clog2(a + 1) - 1;
        kb = $clog2(b + 1) - 1;
        fa = ((a - 2**ka) * 2**(N-1)) / 2**ka;
        fb = ((b - 2**kb) * 2**(N-1)) / 2**kb;
        ff = fa + fb;
        kk = ka + kb;
        if (ff >= 2**(N-1)) begin
            kk = kk + 1;
            ff = ff - 2**(N-1);
        end
        return ((2**(N-1) + ff) * 2**kk) / 2**(N-1);
    endfunction

    task automatic send(input int a, input int b);
        int w;
        exp_t x;
        @(negedge clk);
        in_a = a[N-1:0];
        in_b = b[N-1:0];
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        x.prod = model(a, b);
        x.acc  = cyc + 1;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Consumer-side ready: random when in auto mode, otherwise whatever the test dictates.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_auto ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: latency on first valid, stability while held, product on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_output", 1, 0);
                else chk("latency", cyc - sb[0].acc, 4);
            end
            if (out_valid && prev_v) chk("hold_stable", out_prod, prev_p);
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("prod", out_prod, e.prod);
            end
            prev_v = out_valid;
            prev_p = out_prod;
        end
    end

    initial begin
        int w;
        int ra, rb;
        cyc = 0; n_chk = 0; n_fail = 0;
        rdy_auto = 1'b0; rdy_val = 1'b1;
        prev_v = 1'b0; prev_p = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_prod", out_prod, 0);
        rst_n = 1'b1;

        // Reset in the middle of SUM discards the transaction.
        send(100, 100);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_prod", out_prod, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners.
        send(8, 8);     drain();
        send(3, 3);     drain();
        send(5, 6);     drain();
        send(255, 255); drain();
        send(0, 200);   drain();
        send(1, 1);     drain();

        // Backpressure: hold the product, ignore a stray request, then release for one cycle.
        rdy_val = 1'b0;
        send(200, 13);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            in_valid = 1'b1; in_a = 8'd77; in_b = 8'd99;
        end
        in_valid = 1'b0;
        rdy_val = 1'b1;
        @(negedge clk);
        rdy_val = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        drain();

        // Back-to-back pair under always-ready.
        rdy_val = 1'b1;
        send(5, 6);
        send(255, 255);
        drain();

        // Random traffic with random consumer stalls.
        rdy_auto = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            send(ra, rb);
        end
        drain();
        rdy_auto = 1'b0;
        rdy_val = 1'b1;
        repeat (3) @(negedge clk);
        chk("end_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
